// File: rtl/record_stream_master.sv
// record_stream_master: produces a numbered stream of records on a notify/sync master port
// and consumes 32-bit result words on a notify/sync slave port.
//
// Record k of a run carries x = X_SEED + k and y = k * Y_STEP (both mod 2**32).
// At most MAX_OUTSTANDING records may be sent but not yet answered. The run ends once
// num_records results have been accepted: done pulses for one cycle, and the counters and
// last_result hold until the next accepted start.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start, num_records                run request (1-cycle pulse, ignored while busy) and length
//   rec_out, rec_out_notify           record offered to the consumer; transfer = notify & sync
//   rec_out_sync                      consumer ready
//   result_in, result_in_sync         result word and its valid
//   result_in_notify                  ready for a result; transfer = notify & sync
//   busy, done                        run in progress / 1-cycle end-of-run pulse
//   sent_cnt, recv_cnt, last_result   traffic counters and most recent result word
//   checksum                          only present with RECORD_STREAM_CHECKSUM_EN defined:
//                                     rotate-left-by-one then xor of every accepted result

package record_stream_pkg;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } record_t;
endpackage

module record_stream_master
  import record_stream_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned MAX_OUTSTANDING = 1,
  parameter logic [31:0] X_SEED          = 32'd0,
  parameter logic [31:0] Y_STEP          = 32'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_records,
  output record_t          rec_out,
  output logic             rec_out_notify,
  input  logic             rec_out_sync,
  input  logic [31:0]      result_in,
  input  logic             result_in_sync,
  output logic             result_in_notify,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] recv_cnt,
  output logic [31:0]      last_result
`ifdef RECORD_STREAM_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [31:0]      rec_x_q, rec_x_d;
  logic [31:0]      rec_y_q, rec_y_d;
  logic [31:0]      last_q, last_d;
  logic             rec_xfer, res_xfer;
`ifdef RECORD_STREAM_CHECKSUM_EN
  logic [31:0]      ck_q, ck_d;
`endif

  always_comb begin
    state_d          = state_q;
    num_d            = num_q;
    sent_d           = sent_q;
    recv_d           = recv_q;
    outst_d          = outst_q;
    rec_x_d          = rec_x_q;
    rec_y_d          = rec_y_q;
    last_d           = last_q;
`ifdef RECORD_STREAM_CHECKSUM_EN
    ck_d             = ck_q;
`endif
    rec_out_notify   = 1'b0;
    result_in_notify = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    rec_xfer         = 1'b0;
    res_xfer         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d   = num_records;
          sent_d  = '0;
          recv_d  = '0;
          outst_d = '0;
          last_d  = '0;
          rec_x_d = X_SEED;
          rec_y_d = '0;
`ifdef RECORD_STREAM_CHECKSUM_EN
          ck_d    = '0;
`endif
          state_d = (num_records == '0) ? StFin : StRun;
        end
      end

      StRun: begin
        busy             = 1'b1;
        // Both notifies depend on registered state only, never on the sync inputs.
        rec_out_notify   = (sent_q < num_q) && (outst_q < MaxOut);
        result_in_notify = (outst_q != '0);
        rec_xfer         = rec_out_notify & rec_out_sync;
        res_xfer         = result_in_notify & result_in_sync;

        if (rec_xfer) begin
          sent_d  = sent_q + CntOne;
          // Step to the next record incrementally instead of multiplying k * Y_STEP.
          rec_x_d = rec_x_q + 32'd1;
          rec_y_d = rec_y_q + Y_STEP;
        end

        if (res_xfer) begin
          recv_d = recv_q + CntOne;
          last_d = result_in;
`ifdef RECORD_STREAM_CHECKSUM_EN
          ck_d   = {ck_q[30:0], ck_q[31]} ^ result_in;
`endif
          if (recv_d == num_q) state_d = StFin;
        end

        if (rec_xfer && !res_xfer) begin
          outst_d = outst_q + CntOne;
        end else if (!rec_xfer && res_xfer) begin
          outst_d = outst_q - CntOne;
        end
      end

      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      num_q   <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      outst_q <= '0;
      rec_x_q <= '0;
      rec_y_q <= '0;
      last_q  <= '0;
`ifdef RECORD_STREAM_CHECKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      outst_q <= outst_d;
      rec_x_q <= rec_x_d;
      rec_y_q <= rec_y_d;
      last_q  <= last_d;
`ifdef RECORD_STREAM_CHECKSUM_EN
      ck_q    <= ck_d;
`endif
    end
  end

  assign rec_out.x   = rec_x_q;
  assign rec_out.y   = rec_y_q;
  assign sent_cnt    = sent_q;
  assign recv_cnt    = recv_q;
  assign last_result = last_q;
`ifdef RECORD_STREAM_CHECKSUM_EN
  assign checksum    = ck_q;
`endif

endmodule

// File: tb/tb_record_stream_master.sv
// Bench for record_stream_master. Two instances: u_dut1 (MAX_OUTSTANDING=1, default seeds)
// and u_dut2 (MAX_OUTSTANDING=2, wrapping x seed, large y step). Covers the
// RECORD_STREAM_CHECKSUM_EN checksum port when that macro is defined.
module tb_record_stream_master;
  import record_stream_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] XS1 = 32'd0;
  localparam logic [31:0] YS1 = 32'd3;
  localparam logic [31:0] XS2 = 32'hFFFF_FFFE;
  localparam logic [31:0] YS2 = 32'h4000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, sel;
  logic [CNT_W-1:0] num_records;
  logic             rec_out_sync, result_in_sync;
  logic [31:0]      result_in;
  logic             start1, start2;

  record_t          rec1, rec2, rec_o;
  logic             rn1, rn2, rn_o, qn1, qn2, qn_o;
  logic             busy1, busy2, busy_o, done1, done2, done_o;
  logic [CNT_W-1:0] sent1, sent2, sent_o, recv1, recv2, recv_o;
  logic [31:0]      last1, last2, last_o;
`ifdef RECORD_STREAM_CHECKSUM_EN
  logic [31:0]      ck1, ck2, ck_o;
`endif

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  record_stream_master #(
    .CNT_W(CNT_W), .MAX_OUTSTANDING(1), .X_SEED(XS1), .Y_STEP(YS1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .num_records(num_records),
    .rec_out(rec1), .rec_out_notify(rn1), .rec_out_sync(rec_out_sync),
    .result_in(result_in), .result_in_sync(result_in_sync), .result_in_notify(qn1),
    .busy(busy1), .done(done1), .sent_cnt(sent1), .recv_cnt(recv1), .last_result(last1)
`ifdef RECORD_STREAM_CHECKSUM_EN
    , .checksum(ck1)
`endif
  );

  record_stream_master #(
    .CNT_W(CNT_W), .MAX_OUTSTANDING(2), .X_SEED(XS2), .Y_STEP(YS2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .num_records(num_records),
    .rec_out(rec2), .rec_out_notify(rn2), .rec_out_sync(rec_out_sync),
    .result_in(result_in), .result_in_sync(result_in_sync), .result_in_notify(qn2),
    .busy(busy2), .done(done2), .sent_cnt(sent2), .recv_cnt(recv2), .last_result(last2)
`ifdef RECORD_STREAM_CHECKSUM_EN
    , .checksum(ck2)
`endif
  );

  assign rec_o  = sel ? rec2  : rec1;
  assign rn_o   = sel ? rn2   : rn1;
  assign qn_o   = sel ? qn2   : qn1;
  assign busy_o = sel ? busy2 : busy1;
  assign done_o = sel ? done2 : done1;
  assign sent_o = sel ? sent2 : sent1;
  assign recv_o = sel ? recv2 : recv1;
  assign last_o = sel ? last2 : last1;
`ifdef RECORD_STREAM_CHECKSUM_EN
  assign ck_o   = sel ? ck2   : ck1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // rec_mode/res_mode: 0 sync always 1, 1 random, 2 held low for the first cycles,
  // 3 (res only) always 1 with result word = its 1-based index.
  typedef struct {
    int num;
    int rec_mode;
    int res_mode;
    int s;
    int exp_done_cyc;  // -1: not checked
  } vec_t;

  task automatic run_case(input int num, input int rec_mode, input int res_mode, input int s,
                          input int exp_done_cyc);
    record_t     exp_q[$];
    logic [31:0] res_q[$];
    logic [31:0] xs, ys, m_last, m_ck, rw, exp_last;
    int          m_sent, m_recv, max_out;
    bit          m_fin, finished, exp_rn, exp_qn, rs, qs;
    sel     = (s != 0);
    xs      = sel ? XS2 : XS1;
    ys      = sel ? YS2 : YS1;
    max_out = sel ? 2 : 1;
    for (int k = 0; k < num; k++) begin
      record_t r;
      r.x = xs + 32'(k);
      r.y = 32'(k) * ys;
      exp_q.push_back(r);
    end
    m_sent = 0; m_recv = 0; m_last = '0; m_ck = '0;
    m_fin = (num == 0); finished = 1'b0;
    @(negedge clk);
    start = 1'b1; num_records = CNT_W'(num);
    rec_out_sync = 1'b0; result_in_sync = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (res_q.size() > 0) begin
        exp_last = res_q.pop_front();
        chk("last_result", 64'(last_o), 64'(exp_last));
      end
      if (m_fin) begin
        chk("done_pulse", 64'(done_o), 64'd1);
        chk("busy_in_fin", 64'(busy_o), 64'd0);
        chk("notify_in_fin", 64'({rn_o, qn_o}), 64'd0);
        chk("sent_final", 64'(sent_o), 64'(num));
        chk("recv_final", 64'(recv_o), 64'(num));
        if (exp_done_cyc >= 0) chk("done_latency", 64'(cyc), 64'(exp_done_cyc));
        finished = 1'b1;
        break;
      end
      chk("done_low", 64'(done_o), 64'd0);
      chk("busy_run", 64'(busy_o), 64'd1);
      exp_rn = (m_sent < num) && ((m_sent - m_recv) < max_out);
      exp_qn = (m_sent - m_recv) > 0;
      chk("rec_notify", 64'(rn_o), 64'(exp_rn));
      chk("res_notify", 64'(qn_o), 64'(exp_qn));
      chk("sent_cnt", 64'(sent_o), 64'(m_sent));
      chk("recv_cnt", 64'(recv_o), 64'(m_recv));
      if (exp_rn) chk("rec_out", 64'(rec_o), 64'(exp_q[0]));
      unique case (rec_mode)
        1:       rs = 1'($urandom_range(0, 1));
        2:       rs = (cyc >= 5);
        default: rs = 1'b1;
      endcase
      unique case (res_mode)
        1:       qs = 1'($urandom_range(0, 1));
        2:       qs = (cyc >= 6);
        default: qs = 1'b1;
      endcase
      rw = (res_mode == 3) ? 32'(m_recv + 1) : $urandom;
      rec_out_sync = rs; result_in_sync = qs; result_in = rw;
      // Stray starts during a run must be ignored.
      if (rec_mode == 1) begin
        start = 1'($urandom_range(0, 1));
        num_records = CNT_W'($urandom);
      end
      if (exp_rn && rs) begin
        void'(exp_q.pop_front());
        m_sent++;
      end
      if (exp_qn && qs) begin
        res_q.push_back(rw);
        m_recv++;
        m_last = rw;
        m_ck = {m_ck[30:0], m_ck[31]} ^ rw;
        if (m_recv == num) m_fin = 1'b1;
      end
    end
    start = 1'b0;
    if (!finished) chk("done_timeout", 64'(done_o), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_o), 64'd0);
    chk("idle_not_busy", 64'(busy_o), 64'd0);
    chk("sent_hold", 64'(sent_o), 64'(num));
    chk("recv_hold", 64'(recv_o), 64'(num));
    chk("last_hold", 64'(last_o), 64'(m_last));
`ifdef RECORD_STREAM_CHECKSUM_EN
    chk("checksum", 64'(ck_o), 64'(m_ck));
`endif
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{num: 3, rec_mode: 0, res_mode: 0, s: 0, exp_done_cyc: 6};
    vecs[1] = '{num: 0, rec_mode: 0, res_mode: 0, s: 0, exp_done_cyc: 0};
    vecs[2] = '{num: 4, rec_mode: 2, res_mode: 0, s: 0, exp_done_cyc: 13};
    vecs[3] = '{num: 5, rec_mode: 0, res_mode: 2, s: 1, exp_done_cyc: 11};
    vecs[4] = '{num: 6, rec_mode: 1, res_mode: 1, s: 1, exp_done_cyc: -1};
    vecs[5] = '{num: 7, rec_mode: 1, res_mode: 1, s: 0, exp_done_cyc: -1};

    rst = 1'b1; start = 1'b0; sel = 1'b0; num_records = '0;
    rec_out_sync = 1'b0; result_in_sync = 1'b0; result_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rec_out1", 64'(rec1), 64'd0);
    chk("rst_notify1", 64'({rn1, qn1}), 64'd0);
    chk("rst_busy_done1", 64'({busy1, done1}), 64'd0);
    chk("rst_counts1", 64'({sent1, recv1}), 64'd0);
    chk("rst_last1", 64'(last1), 64'd0);
    chk("rst_rec_out2", 64'(rec2), 64'd0);
    chk("rst_flags2", 64'({rn2, qn2, busy2, done2}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_case(vecs[i].num, vecs[i].rec_mode, vecs[i].res_mode, vecs[i].s,
               vecs[i].exp_done_cyc);
    end

    // Reset in the middle of a 4-record run, after two records went out.
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; num_records = 16'd4;
    rec_out_sync = 1'b1; result_in_sync = 1'b1; result_in = 32'hAA;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_sent", 64'(sent1), 64'd2);
    chk("mid_recv", 64'(recv1), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rec_out", 64'(rec1), 64'd0);
    chk("rst_mid_flags", 64'({rn1, qn1, busy1, done1}), 64'd0);
    chk("rst_mid_counts", 64'({sent1, recv1}), 64'd0);
    chk("rst_mid_last", 64'(last1), 64'd0);
    @(negedge clk);
    chk("rst_no_done", 64'(done1), 64'd0);
    rst = 1'b0; rec_out_sync = 1'b0; result_in_sync = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'({busy1, done1}), 64'd0);
    run_case(4, 0, 0, 0, 8);

    // Results 0x1 then 0x2.
    run_case(2, 0, 3, 0, 4);
    chk("ck_last_result", 64'(last1), 64'h2);
`ifdef RECORD_STREAM_CHECKSUM_EN
    chk("ck_value", 64'(ck1), 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
